// File: rtl/secuenciador_unidad_logica.sv
// secuenciador_unidad_logica
// Bit-serial logic/arithmetic unit. A single 1-bit slice is applied to the
// captured operands LSB first, one bit per clock. The result is shifted in
// from the MSB side and published only when the last bit is done.
//
// Configuration macro: SECUENCIADOR_SUMA_EN
//   defined   : code 11 = serial ADD with carry chain, cout = final carry
//   undefined : code 11 = XNOR, no carry register, cout tied to 0
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   inicio     in   start request, sampled only in IDLE
//   a, b       in   operands (WIDTH), captured on an accepted start
//   op1, op2   in   operation select {op2,op1}: 00 AND, 01 OR, 10 XOR, 11 ADD/XNOR
//   resultado  out  registered result, updated only when entering FIN
//   cout       out  registered final carry
//   ocupado    out  high in CALC and FIN
//   listo      out  one-cycle pulse in FIN
//
// state | meaning
// IDLE  | waiting for inicio, outputs held
// CALC  | one operand bit processed per cycle, WIDTH cycles
// FIN   | result valid, listo high for this one cycle
module secuenciador_unidad_logica #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op1,
  input  logic             op2,
  output logic [WIDTH-1:0] resultado,
  output logic             cout,
  output logic             ocupado,
  output logic             listo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t;

  estado_t          r_estado;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  // Only WIDTH-1 bits are kept; the bit computed in the last CALC cycle goes
  // straight into resultado together with these.
  logic [WIDTH-2:0] r_shift;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_bit;
  logic             w_carry_sig;
  logic [WIDTH-1:0] w_next;
  logic             w_ultimo;

`ifdef SECUENCIADOR_SUMA_EN
  logic r_carry;
`endif

  assign w_a_bit  = r_a[r_cnt];
  assign w_b_bit  = r_b[r_cnt];
  assign w_next   = {w_bit, r_shift};
  assign w_ultimo = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_bit       = 1'b0;
    w_carry_sig = 1'b0;
    case (r_op)
      2'b00: w_bit = w_a_bit & w_b_bit;
      2'b01: w_bit = w_a_bit | w_b_bit;
      2'b10: w_bit = w_a_bit ^ w_b_bit;
      default: begin
`ifdef SECUENCIADOR_SUMA_EN
        w_bit       = w_a_bit ^ w_b_bit ^ r_carry;
        w_carry_sig = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));
`else
        w_bit       = ~(w_a_bit ^ w_b_bit);
`endif
      end
    endcase
  end

`ifndef SECUENCIADOR_SUMA_EN
  assign cout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 2'b00;
      r_shift   <= '0;
      resultado <= '0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
`ifdef SECUENCIADOR_SUMA_EN
      r_carry   <= 1'b0;
      cout      <= 1'b0;
`endif
    end else begin
      listo <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (inicio) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= {op2, op1};
            r_cnt    <= '0;
            ocupado  <= 1'b1;
            r_estado <= CALC;
`ifdef SECUENCIADOR_SUMA_EN
            r_carry  <= 1'b0;
`endif
          end
        end
        CALC: begin
          r_shift <= w_next[WIDTH-1:1];
          r_cnt   <= r_cnt + CW'(1);
`ifdef SECUENCIADOR_SUMA_EN
          r_carry <= w_carry_sig;
`endif
          if (w_ultimo) begin
            resultado <= w_next;
            listo     <= 1'b1;
            r_estado  <= FIN;
`ifdef SECUENCIADOR_SUMA_EN
            cout      <= w_carry_sig;
`endif
          end
        end
        FIN: begin
          ocupado  <= 1'b0;
          r_estado <= IDLE;
        end
        default: begin
          ocupado  <= 1'b0;
          r_estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_unidad_logica.sv
// Bench for secuenciador_unidad_logica (WIDTH=8). A transaction-level model
// (age counter since accept, arithmetic result) is checked against the DUT on
// every cycle; directed operations pin literal results and latencies.
module tb_secuenciador_unidad_logica;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inicio;
  logic [W-1:0] a, b;
  logic         op1, op2;
  logic [W-1:0] resultado;
  logic         cout, ocupado, listo;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  secuenciador_unidad_logica #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .a(a), .b(b),
    .op1(op1), .op2(op2), .resultado(resultado), .cout(cout),
    .ocupado(ocupado), .listo(listo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, x & y};
      2'b01:   return {1'b0, x | y};
      2'b10:   return {1'b0, x ^ y};
`ifdef SECUENCIADOR_SUMA_EN
      default: return {1'b0, x} + {1'b0, y};
`else
      default: return {1'b0, ~(x ^ y)};
`endif
    endcase
  endfunction

  // Model: m_age = cycles since the accepting edge (0 = idle). Result appears
  // in cycle W+1 and the unit is idle again one cycle later.
  int           m_age;
  logic [W-1:0] m_a, m_b, m_res;
  logic [1:0]   m_op;
  logic         m_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= 0;
      m_res  <= '0;
      m_cout <= 1'b0;
    end else if (m_age == 0) begin
      if (inicio) begin
        m_age <= 1;
        m_a   <= a;
        m_b   <= b;
        m_op  <= {op2, op1};
      end
    end else if (m_age == W + 1) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
      if (m_age == W) {m_cout, m_res} <= ref_op(m_a, m_b, m_op);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_resultado", resultado, m_res);
      chk("model_cout", cout, m_cout);
      chk("model_ocupado", ocupado, m_age != 0);
      chk("model_listo", listo, m_age == W + 1);
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [1:0] op, input logic [W-1:0] eres, input logic ecout);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; {op2, op1} = op; inicio = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    chk({nm, "_busy"}, ocupado, 1'b1);
    @(negedge clk);
    inicio = 1'b0;
    while (listo !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, W + 1);
    chk({nm, "_res"}, resultado, eres);
    chk({nm, "_cout"}, cout, ecout);
    @(posedge clk); #1;
    chk({nm, "_idle"}, {ocupado, listo}, 2'b00);
  endtask

  initial begin
    int nl;
    int t[4];
    logic [W-1:0] r_seen;
    rst_n = 1'b0; inicio = 1'b0; a = '0; b = '0; op1 = 1'b0; op2 = 1'b0;
    #12;
    chk("rst_resultado", resultado, 0);
    chk("rst_flags", {cout, ocupado, listo}, 3'b000);
    chk_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    run_op("and", 8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0);
    run_op("xor", 8'hA5, 8'h0F, 2'b10, 8'hAA, 1'b0);
    run_op("or",  8'hA5, 8'h0F, 2'b01, 8'hAF, 1'b0);
`ifdef SECUENCIADOR_SUMA_EN
    run_op("add_ff01", 8'hFF, 8'h01, 2'b11, 8'h00, 1'b1);
`else
    run_op("xnor_ff01", 8'hFF, 8'h01, 2'b11, 8'h01, 1'b0);
`endif

    // Retrigger and operand change while busy must be ignored.
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; {op2, op1} = 2'b11; inicio = 1'b1;
    @(negedge clk); inicio = 1'b0;
    repeat (3) @(negedge clk);
    inicio = 1'b1; a = 8'hFF; {op2, op1} = 2'b00;
    @(negedge clk); inicio = 1'b0;
    nl = 0; r_seen = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (listo) begin nl++; r_seen = resultado; end
    end
    chk("busy_ignore_listo_count", nl, 1);
`ifdef SECUENCIADOR_SUMA_EN
    chk("busy_ignore_res", r_seen, 8'h4B);
`else
    chk("busy_ignore_res", r_seen, 8'hCC);
`endif

    // Reset during CALC cycle 4.
    @(negedge clk);
    a = 8'h12; b = 8'h34; {op2, op1} = 2'b01; inicio = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); inicio = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("midrst_resultado", resultado, 0);
    chk("midrst_flags", {cout, ocupado, listo}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nl = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (listo) nl++;
    end
    chk("midrst_no_listo", nl, 0);
`ifdef SECUENCIADOR_SUMA_EN
    run_op("after_rst", 8'h12, 8'h34, 2'b11, 8'h46, 1'b0);
    run_op("add_carry", 8'h80, 8'h81, 2'b11, 8'h01, 1'b1);
`else
    run_op("after_rst", 8'h12, 8'h34, 2'b11, 8'hD9, 1'b0);
`endif

    // inicio held high: one operation every W+2 cycles, operands changing.
    @(negedge clk);
    a = 8'h11; b = 8'h22; {op2, op1} = 2'b11; inicio = 1'b1;
    nl = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (listo && nl < 4) begin t[nl] = i; nl++; end
      @(negedge clk);
      a = a + 8'h13;
      b = b ^ 8'h5A;
      {op2, op1} = {op2, op1} + 2'b01;
    end
    inicio = 1'b0;
    chk("held_listo_count", nl, 3);
    chk("held_first_listo", t[0], W);
    chk("held_period_1", t[1] - t[0], W + 2);
    chk("held_period_2", t[2] - t[1], W + 2);
    repeat (14) @(posedge clk);
    #2;
    chk("final_idle", {ocupado, listo}, 2'b00);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/secuenciador_unidad_logica.md
SECUENCIADOR_UNIDAD_LOGICA -- requirements
Module: secuenciador_unidad_logica

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port inicio  input  1  start request, sampled only in state IDLE.
REQ-005 SHALL provide port a  input  WIDTH  operand A, captured when a start is accepted.
REQ-006 SHALL provide port b  input  WIDTH  operand B, captured when a start is accepted.
REQ-007 SHALL provide port op1  input  1  operation select, low bit, captured when a start is accepted.
REQ-008 SHALL provide port op2  input  1  operation select, high bit, captured when a start is accepted.
REQ-009 SHALL provide port resultado  output  WIDTH  registered result, held stable outside state CALC.
REQ-010 SHALL provide port cout  output  1  registered final carry out of the last bit slice.
REQ-011 SHALL provide port ocupado  output  1  high while the state is CALC or FIN.
REQ-012 SHALL provide port listo  output  1  one-cycle pulse marking a valid resultado and cout.

Function
REQ-013 SHALL contain one internal 1-bit logic slice and apply it to operand bits serially, LSB first, one bit per clock.
REQ-014 SHALL select the slice function from {op2,op1}: 00 AND, 01 OR, 10 XOR, 11 ADD (a_i + b_i + carry_i, sum to result bit, carry out to carry_(i+1)).
REQ-015 SHALL clear carry_0 to 0 at the start of every operation.
REQ-016 SHALL use states IDLE, CALC and FIN, with a bit counter of ceil(log2(WIDTH)) bits.
REQ-017 SHALL, in IDLE with inicio=1, latch a, b, op1 and op2, clear the counter and carry, and move to CALC on the next edge.
REQ-018 SHALL, in IDLE with inicio=0, remain in IDLE with all outputs unchanged.
REQ-019 SHALL, in each CALC cycle, compute bit[counter], shift it into the result register from the MSB side, update carry and increment the counter.
REQ-020 SHALL move from CALC to FIN on the edge that processes bit WIDTH-1, so CALC lasts exactly WIDTH cycles.
REQ-021 SHALL, in FIN, drive resultado with the full result, drive cout with the final carry (0 for logic operations), assert listo for exactly one cycle, and return to IDLE on the next edge.
REQ-022 SHALL make the latency from the edge that samples inicio to the cycle in which listo is high exactly WIDTH+1 cycles.
REQ-023 SHALL ignore inicio while ocupado=1, with no queuing.
REQ-024 SHALL ignore changes on a, b, op1 and op2 after capture, until the next accepted start.
REQ-025 SHALL hold resultado and cout from FIN until the next operation's FIN; intermediate shift values SHALL NOT be visible on resultado.
REQ-026 SHALL allow back-to-back operations: inicio=1 in the cycle after FIN (state IDLE) is accepted.
REQ-027 SHALL NOT record an ADD overflow beyond WIDTH bits except through cout.

Reset
REQ-028 SHALL, while rst_n=0, force state to IDLE, counter to 0, carry to 0, resultado to 0, cout to 0, ocupado to 0 and listo to 0, independent of clk.
REQ-029 SHALL, on reset asserted mid-CALC, abort the operation with no listo pulse and keep the previous resultado cleared to 0.
REQ-030 SHALL resume start acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL gate the ADD function with macro SECUENCIADOR_SUMA_EN.
REQ-032 SHALL, with SECUENCIADOR_SUMA_EN defined, implement code 11 as serial ADD per REQ-014.
REQ-033 SHALL, with SECUENCIADOR_SUMA_EN undefined, implement code 11 as XNOR, remove the carry register, and tie cout to 0; timing is unchanged.

Verification
REQ-034 SHALL cover: WIDTH=8, a=8'hF0, b=8'h3C, op=00 -> resultado=8'h30, cout=0, listo in cycle 9 after the inicio sample.
REQ-035 SHALL cover: a=8'hA5, b=8'h0F, op=10 -> resultado=8'hAA; op=01 -> resultado=8'hAF.
REQ-036 SHALL cover: SUMA_EN defined, a=8'hFF, b=8'h01, op=11 -> resultado=8'h00, cout=1; undefined -> resultado=8'h01, cout=0.
REQ-037 SHALL cover: inicio pulsed again and a changed mid-CALC -> ignored, first result unchanged, exactly one listo.
REQ-038 SHALL cover: rst_n low during CALC cycle 4 -> all outputs 0 immediately, no listo, next start completes normally.
REQ-039 SHALL cover: inicio held high continuously -> listo every WIDTH+2 cycles with correct results.
